nx_indirect_access_arb: RTL

Arbiter that shares one register-array access port (chip-select, write-enable, address, write data, read data) between `N_REQ` indirect-access controllers. It uses a round-robin grant/yield handshake. It sits between the indirect-access control blocks (software command path, hardware snapshot engines) and a single `nx_*reg_indirect_access` storage array. It sequences ownership, muxes the owner's access onto the memory port and routes registered read data back to the owner.

---
 rtl/nx_arb_typePKG.sv | 12 +
 rtl/nx_rr_pick.sv | 30 +++
 rtl/nx_indirect_access_arb.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nx_arb_typePKG.sv
// Shared types for the indirect-access arbiter: FSM state encoding and hold-counter width.
package nx_arb_typePKG;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last_owner+1, wrapping.
module nx_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned OWN_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] last_owner,
  output logic [N_REQ-1:0] winner,
  output logic             any
);

  logic             found;
  logic [OWN_W-1:0] idx;

  assign any = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = OWN_W'((32'(last_owner) + 32'd1 + i) % N_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nx_indirect_access_arb.sv
// Round-robin grant/yield arbiter sharing one register-array port between N_REQ controllers.
// Optional error counter ports are enabled by NX_INDIRECT_ARB_ERR_CNT_EN.
module nx_indirect_access_arb
  import nx_arb_typePKG::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned N_ADDR_BITS = 5,
  parameter int unsigned N_DATA_BITS = 64,
  parameter int unsigned N_ENTRIES   = 32,
  parameter int unsigned MAX_HOLD    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               yield,
  output logic [N_REQ-1:0]               grant,
  output logic [N_REQ-1:0]               preempt,
  input  logic [N_REQ-1:0]               sw_cs,
  input  logic [N_REQ-1:0]               sw_we,
  input  logic [N_REQ*N_ADDR_BITS-1:0]   sw_add,
  input  logic [N_REQ*N_DATA_BITS-1:0]   sw_wdat,
  output logic [N_DATA_BITS-1:0]         sw_rdat,
  output logic [N_REQ-1:0]               rd_vld,
  output logic                           mem_cs,
  output logic                           mem_we,
  output logic [N_ADDR_BITS-1:0]         mem_add,
  output logic [N_DATA_BITS-1:0]         mem_wdat,
  input  logic [N_DATA_BITS-1:0]         mem_rdat,
  output logic                           err
`ifdef NX_INDIRECT_ARB_ERR_CNT_EN
  ,
  input  logic                           err_cnt_clr,
  output logic [7:0]                     err_cnt
`endif
);

  localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state, state_nxt;
  logic [N_REQ-1:0]  grant_nxt, preempt_nxt, rd_vld_nxt;
  logic [OWN_W-1:0]  owner, owner_nxt, last_owner, last_owner_nxt, win_idx;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [N_REQ-1:0]  win;
  logic              win_any;
  logic              own_cs, own_oor, rd_oor, rd_oor_nxt;
  logic [N_ADDR_BITS-1:0] own_add;
  logic [N_DATA_BITS-1:0] own_wdat;

  nx_rr_pick #(
    .N_REQ (N_REQ),
    .OWN_W (OWN_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (win),
    .any        (win_any)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = OWN_W'(i);
    end
  end

  // Owner's access port, live only while a tenure is active.
  always_comb begin
    own_add  = sw_add[32'(owner)*N_ADDR_BITS +: N_ADDR_BITS];
    own_wdat = sw_wdat[32'(owner)*N_DATA_BITS +: N_DATA_BITS];
    own_cs   = (state == OWN) && sw_cs[owner];
    own_oor  = own_cs && (32'(own_add) >= N_ENTRIES);
    mem_cs   = own_cs && !own_oor;
    mem_we   = mem_cs && sw_we[owner];
    mem_add  = (state == OWN) ? own_add : '0;
    mem_wdat = (state == OWN) ? own_wdat : '0;
    err      = own_oor || (|(sw_cs & ~grant));
    sw_rdat  = (|rd_vld && !rd_oor) ? mem_rdat : '0;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    hold_nxt       = hold_cnt;
    preempt_nxt    = '0;
    rd_vld_nxt     = '0;
    rd_oor_nxt     = 1'b0;
    if (own_cs && !sw_we[owner]) begin
      rd_vld_nxt = grant;
      rd_oor_nxt = own_oor;
    end
    unique case (state)
      IDLE, RELEASE: begin
        if (win_any) begin
          state_nxt = OWN;
          grant_nxt = win;
          owner_nxt = win_idx;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      OWN: begin
        if (yield[owner]) begin
          state_nxt      = RELEASE;
          grant_nxt      = '0;
          last_owner_nxt = owner;
        end else begin
          if (hold_cnt != '1) hold_nxt = hold_cnt + HOLD_W'(1);
          if (32'(hold_nxt) >= MAX_HOLD && |(req & ~grant)) preempt_nxt = grant;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= OWN_W'(N_REQ - 1);
      hold_cnt   <= '0;
      preempt    <= '0;
      rd_vld     <= '0;
      rd_oor     <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_nxt;
      preempt    <= preempt_nxt;
      rd_vld     <= rd_vld_nxt;
      rd_oor     <= rd_oor_nxt;
    end
  end

`ifdef NX_INDIRECT_ARB_ERR_CNT_EN
  // Saturating error event counter; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
